// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic stage for the ALU datapath.
// One of eight bitwise functions on two WIDTH-bit operands, with an
// accumulate mode that substitutes the previous result for operand A.
// Valid/ready on both sides; a single output register, no skid buffer.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones,
   output logic             parity
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NAND = 3'b011,
      OP_NOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_NOT  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             out_valid_q, out_valid_d;
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;
   logic             parity_q, parity_d;

   logic             accept;
   logic             consume;
   logic [WIDTH-1:0] acc_eff;
   logic [WIDTH-1:0] x_opnd;
   logic [WIDTH-1:0] result;
   op_e              op_fn;

   // Handshake: the output register can take a new beat when empty or draining.
   always_comb begin
      in_ready = !out_valid_q || out_ready;
      accept   = in_valid && in_ready;
      consume  = out_valid_q && out_ready;
   end

   // Operand selection and the bitwise function itself.
   always_comb begin
      acc_eff = acc_clear ? '0 : acc_q;
      x_opnd  = op[3] ? acc_eff : a;
      op_fn   = op_e'(op[2:0]);
      result  = '0;
      case (op_fn)
         OP_AND:  result = x_opnd & b;
         OP_OR:   result = x_opnd | b;
         OP_XOR:  result = x_opnd ^ b;
         OP_NAND: result = ~(x_opnd & b);
         OP_NOR:  result = ~(x_opnd | b);
         OP_XNOR: result = ~(x_opnd ^ b);
         OP_NOT:  result = ~x_opnd;
         OP_PASS: result = x_opnd;
         default: result = '0;
      endcase
   end

   // Next-state: accepted beats load result, flags and accumulator together.
   always_comb begin
      y_d         = y_q;
      zero_d      = zero_q;
      ones_d      = ones_q;
      parity_d    = parity_q;
      out_valid_d = out_valid_q;
      // Without an accepted beat acc_eff is either acc_q or the cleared value,
      // so a lone acc_clear is handled by the same expression.
      acc_d       = acc_eff;
      if (accept) begin
         y_d         = result;
         zero_d      = ~|result;
         ones_d      = &result;
         parity_d    = ^result;
         out_valid_d = 1'b1;
         acc_d       = result;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b1;
         ones_q      <= 1'b0;
         parity_q    <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
         ones_q      <= ones_d;
         parity_q    <= parity_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign ones      = ones_q;
   assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: WIDTH=8 with a reference model, plus
// op sweeps on WIDTH=16 and WIDTH=1 instances.
module tb_logic_unit_pipe;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       v8 = 1'b0, clr8 = 1'b0, ordy8 = 1'b1;
   logic [3:0] op8 = '0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ir8, ov8, z8, o8, p8;
   logic [7:0] y8;

   logic_unit_pipe #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
      .acc_clear(clr8), .out_valid(ov8), .out_ready(ordy8), .y(y8),
      .zero(z8), .ones(o8), .parity(p8));

   // WIDTH=16 instance
   logic        v16 = 1'b0, clr16 = 1'b0, ordy16 = 1'b1;
   logic [3:0]  op16 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        ir16, ov16, z16, o16, p16;
   logic [15:0] y16;

   logic_unit_pipe #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
      .acc_clear(clr16), .out_valid(ov16), .out_ready(ordy16), .y(y16),
      .zero(z16), .ones(o16), .parity(p16));

   // WIDTH=1 instance
   logic       v1 = 1'b0, clr1 = 1'b0, ordy1 = 1'b1;
   logic [3:0] op1 = '0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       ir1, ov1, z1, o1, p1;
   logic [0:0] y1;

   logic_unit_pipe #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .op(op1), .a(a1), .b(b1),
      .acc_clear(clr1), .out_valid(ov1), .out_ready(ordy1), .y(y1),
      .zero(z1), .ones(o1), .parity(p1));

   // Reference model state for the WIDTH=8 instance
   logic [7:0] m_acc = '0;
   logic [7:0] m_y   = '0;
   logic       m_vld = 1'b0;

   // Bitwise function on up to 16 bits, truncated to w bits
   function automatic logic [15:0] ref_op(input logic [2:0] o, input logic [15:0] x,
                                          input logic [15:0] bb, input int w);
      logic [16:0] full;
      logic [15:0] r;
      full = (17'd1 << w) - 17'd1;
      case (o)
         3'd0: r = x & bb;
         3'd1: r = x | bb;
         3'd2: r = x ^ bb;
         3'd3: r = ~(x & bb);
         3'd4: r = ~(x | bb);
         3'd5: r = ~(x ^ bb);
         3'd6: r = ~x;
         default: r = x;
      endcase
      return r & full[15:0];
   endfunction

   task automatic drive8(input logic v, input logic [3:0] o, input logic [7:0] aa,
                         input logic [7:0] bb, input logic clr, input logic ordy);
      v8 = v; op8 = o; a8 = aa; b8 = bb; clr8 = clr; ordy8 = ordy;
   endtask

   // Advance the model by one clock using the current drive, then clock the DUT
   task automatic tick8;
      logic        rdy;
      logic [7:0]  xe;
      logic [15:0] r;
      rdy = !m_vld || ordy8;
      xe  = op8[3] ? (clr8 ? 8'h00 : m_acc) : a8;
      r   = ref_op(op8[2:0], {8'h00, xe}, {8'h00, b8}, 8);
      if (v8 && rdy) begin
         m_y = r[7:0]; m_vld = 1'b1; m_acc = r[7:0];
      end else begin
         if (m_vld && ordy8) m_vld = 1'b0;
         if (clr8) m_acc = 8'h00;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov8); end
      checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp 00", y8); end
      checks++; if ({z8, o8, p8} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp 100", {z8, o8, p8}); end
      checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ir8); end
      checks++; if ({ov1, z1, o1, p1} !== 4'b0100) begin errors++; $display("FAIL reset_w1 got %b exp 0100", {ov1, z1, o1, p1}); end
      rst = 1'b0;
      m_acc = '0; m_y = '0; m_vld = 1'b0;
   endtask

   task automatic test_and;
      drive8(1'b1, 4'h0, 8'hF0, 8'h3C, 1'b0, 1'b1);
      tick8;
      checks++; if (y8 !== 8'h30) begin errors++; $display("FAIL and_y got %h exp 30", y8); end
      checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL and_valid got %b exp 1", ov8); end
      checks++; if ({z8, o8, p8} !== 3'b000) begin errors++; $display("FAIL and_flags got %b exp 000", {z8, o8, p8}); end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL and_drain got %b exp 0", ov8); end
   endtask

   task automatic test_ops_sweep;
      logic [7:0] exp_y [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
      for (int i = 0; i < 8; i++) begin
         drive8(1'b1, 4'(i), 8'hA5, 8'h0F, 1'b0, 1'b1);
         tick8;
         checks++; if (y8 !== exp_y[i] || ov8 !== 1'b1)
            begin errors++; $display("FAIL sweep_op%0d got y=%h v=%b exp y=%h v=1", i, y8, ov8, exp_y[i]); end
      end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
   endtask

   task automatic test_accumulate;
      logic [3:0] ops [7] = '{4'hF, 4'h9, 4'h9, 4'h9, 4'h9, 4'h8, 4'hF};
      logic [7:0] bs  [7] = '{8'h55, 8'h01, 8'h02, 8'h04, 8'h80, 8'h0F, 8'h33};
      logic       cl  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [7:0] ex  [7] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h87, 8'h07, 8'h00};
      for (int i = 0; i < 7; i++) begin
         drive8(1'b1, ops[i], 8'hC3, bs[i], cl[i], 1'b1);
         tick8;
         checks++; if (y8 !== ex[i] || ov8 !== 1'b1)
            begin errors++; $display("FAIL acc_step%0d got y=%h v=%b exp y=%h v=1", i, y8, ov8, ex[i]); end
      end
      checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL acc_clear_zero got %b exp 1", z8); end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
   endtask

   task automatic test_backpressure;
      logic [7:0] stall_b [3] = '{8'h10, 8'h20, 8'h40};
      // acc is 00 here; XOR-acc b=01 -> 01
      drive8(1'b1, 4'hA, 8'h00, 8'h01, 1'b0, 1'b1);
      tick8;
      checks++; if (y8 !== 8'h01) begin errors++; $display("FAIL bp_first got %h exp 01", y8); end
      for (int i = 0; i < 3; i++) begin
         drive8(1'b1, 4'hA, 8'h00, stall_b[i], 1'b0, 1'b0);
         #1;
         checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b exp 0", i, ir8); end
         tick8;
         checks++; if (y8 !== 8'h01 || ov8 !== 1'b1)
            begin errors++; $display("FAIL bp_hold%0d got y=%h v=%b exp y=01 v=1", i, y8, ov8); end
      end
      drive8(1'b1, 4'hA, 8'h00, 8'h04, 1'b0, 1'b1);
      #1;
      checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", ir8); end
      tick8;
      checks++; if (y8 !== 8'h05 || ov8 !== 1'b1)
         begin errors++; $display("FAIL bp_release got y=%h v=%b exp y=05 v=1", y8, ov8); end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
   endtask

   task automatic test_flags;
      drive8(1'b1, 4'h4, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
      checks++; if ({y8, z8, o8, p8} !== {8'hFF, 3'b010})
         begin errors++; $display("FAIL flags_nor got y=%h zop=%b exp y=ff zop=010", y8, {z8, o8, p8}); end
      drive8(1'b1, 4'h2, 8'h01, 8'h00, 1'b0, 1'b1);
      tick8;
      checks++; if ({y8, z8, o8, p8} !== {8'h01, 3'b001})
         begin errors++; $display("FAIL flags_xor got y=%h zop=%b exp y=01 zop=001", y8, {z8, o8, p8}); end
      drive8(1'b1, 4'h0, 8'hFF, 8'h00, 1'b0, 1'b1);
      tick8;
      checks++; if ({y8, z8, o8, p8} !== {8'h00, 3'b100})
         begin errors++; $display("FAIL flags_and got y=%h zop=%b exp y=00 zop=100", y8, {z8, o8, p8}); end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
   endtask

   task automatic test_async_reset;
      drive8(1'b1, 4'hF, 8'h00, 8'h00, 1'b1, 1'b1);
      tick8;
      drive8(1'b1, 4'h9, 8'h00, 8'h87, 1'b0, 1'b1);
      tick8;
      checks++; if (y8 !== 8'h87 || ov8 !== 1'b1)
         begin errors++; $display("FAIL ar_setup got y=%h v=%b exp y=87 v=1", y8, ov8); end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL ar_immediate got %b exp 0", ov8); end
      m_acc = '0; m_y = '0; m_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL ar_no_beat got %b exp 0", ov8); end
      drive8(1'b1, 4'hF, 8'hAA, 8'h00, 1'b0, 1'b1);
      tick8;
      checks++; if (y8 !== 8'h00 || ov8 !== 1'b1)
         begin errors++; $display("FAIL ar_acc_cleared got y=%h v=%b exp y=00 v=1", y8, ov8); end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
   endtask

   task automatic test_random;
      for (int i = 0; i < 300; i++) begin
         drive8(1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
         #1;
         checks++; if (ir8 !== (!m_vld || ordy8))
            begin errors++; $display("FAIL rand_in_ready%0d got %b exp %b", i, ir8, (!m_vld || ordy8)); end
         tick8;
         checks++; if (ov8 !== m_vld || y8 !== m_y)
            begin errors++; $display("FAIL rand_out%0d got y=%h v=%b exp y=%h v=%b", i, y8, ov8, m_y, m_vld); end
         checks++; if ({z8, o8, p8} !== {(m_y == 8'h00), (m_y == 8'hFF), ^m_y})
            begin errors++; $display("FAIL rand_flags%0d got %b for y=%h", i, {z8, o8, p8}, m_y); end
      end
      drive8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      tick8;
   endtask

   task automatic test_width16;
      logic [15:0] e;
      for (int i = 0; i < 8; i++) begin
         v16 = 1'b1; op16 = 4'(i); a16 = 16'($urandom); b16 = 16'($urandom);
         e = ref_op(3'(i), a16, b16, 16);
         @(posedge clk); #1;
         checks++; if (y16 !== e || ov16 !== 1'b1)
            begin errors++; $display("FAIL w16_op%0d got y=%h v=%b exp y=%h v=1", i, y16, ov16, e); end
         checks++; if ({z16, o16, p16} !== {(e == 16'h0000), (e == 16'hFFFF), ^e})
            begin errors++; $display("FAIL w16_flags%0d got %b for y=%h", i, {z16, o16, p16}, e); end
      end
      v16 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_width1;
      logic [15:0] e;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) begin
            v1 = 1'b1; op1 = 4'(i); a1 = 1'(j >> 1); b1 = 1'(j);
            e = ref_op(3'(i), {15'd0, a1}, {15'd0, b1}, 1);
            @(posedge clk); #1;
            checks++; if (y1 !== e[0:0] || ov1 !== 1'b1 || p1 !== e[0] || z1 !== ~e[0] || o1 !== e[0])
               begin errors++; $display("FAIL w1_op%0d_ab%0d got y=%b v=%b zop=%b exp y=%b", i, j, y1, ov1, {z1, o1, p1}, e[0]); end
         end
      end
      v1 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #1;
      test_reset;
      test_and;
      test_ops_sweep;
      test_accumulate;
      test_backpressure;
      test_flags;
      test_async_reset;
      test_random;
      test_width16;
      test_width1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
